// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage behind the ALU control decoder.
// Single-cycle ALU operations, iterative one-bit-per-cycle shifts, and a
// valid/ready handshake on both sides. Result and flags are held until consumed.
module alu_exec_unit #(
   parameter int WIDTH           = 32,
   parameter bit ITERATIVE_SHIFT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic             shamt_sel,
   input  logic [4:0]       shamt_in,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             op_err
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_BNE  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_LUI  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1111;

   state_t           state_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [WIDTH-1:0] result_reg;
   logic             zero_reg;
   logic             overflow_reg;
   logic             op_err_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [4:0]       count_reg;
   logic             shift_right_reg;
   logic             shift_arith_reg;

   logic [4:0]       shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] calc_result;
   logic             calc_overflow;
   logic             calc_err;
   logic             is_shift;
   logic [WIDTH-1:0] shift_step;
   logic             shift_fill;

   assign shamt = shamt_sel ? shamt_in : operand_a[4:0];
   assign sum   = operand_a + operand_b;
   assign diff  = operand_a - operand_b;

   // Single-cycle datapath: evaluates the presented request so it can be registered on accept
   always_comb begin
      calc_result   = '0;
      calc_overflow = 1'b0;
      calc_err      = 1'b0;
      is_shift      = 1'b0;
      case (alu_control)
         OP_ADD: begin
            calc_result   = sum;
            calc_overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SUB, OP_BNE: begin
            calc_result   = diff;
            calc_overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                            (diff[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_SLT:  calc_result = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         OP_SLTU: calc_result = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
         OP_AND:  calc_result = operand_a & operand_b;
         OP_OR:   calc_result = operand_a | operand_b;
         OP_XOR:  calc_result = operand_a ^ operand_b;
         OP_LUI:  calc_result = WIDTH'(operand_b[15:0]) << 16;
         OP_SLL: begin
            is_shift    = 1'b1;
            calc_result = operand_b << shamt;
         end
         OP_SRL: begin
            is_shift    = 1'b1;
            calc_result = operand_b >> shamt;
         end
         OP_SRA: begin
            is_shift    = 1'b1;
            calc_result = $signed(operand_b) >>> shamt;
         end
         OP_NOR:  calc_result = ~(operand_a | operand_b);
         // Unused codes (and unknown values in simulation) report an error with a zero result
         default: calc_err = 1'b1;
      endcase
   end

   // One-bit shift step of the iterative shifter; left shifts zero-fill the LSB,
   // right shifts fill the MSB with zero or the sign bit
   assign shift_fill = shift_arith_reg & shift_reg[WIDTH-1];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_step
         if (gi == 0) begin : g_lsb
            assign shift_step[gi] = shift_right_reg ? shift_reg[gi+1] : 1'b0;
         end else if (gi == WIDTH-1) begin : g_msb
            assign shift_step[gi] = shift_right_reg ? shift_fill : shift_reg[gi-1];
         end else begin : g_mid
            assign shift_step[gi] = shift_right_reg ? shift_reg[gi+1] : shift_reg[gi-1];
         end
      end
   endgenerate

   // Control FSM with registered handshake outputs, result and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         in_ready_reg    <= 1'b1;
         out_valid_reg   <= 1'b0;
         result_reg      <= '0;
         zero_reg        <= 1'b1;
         overflow_reg    <= 1'b0;
         op_err_reg      <= 1'b0;
         shift_reg       <= '0;
         count_reg       <= '0;
         shift_right_reg <= 1'b0;
         shift_arith_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  in_ready_reg <= 1'b0;
                  if (ITERATIVE_SHIFT && is_shift && (shamt != 5'd0)) begin
                     // SLL=1001, SRL=1010, SRA=1011: bit 1 selects right, bit 0 with it selects arithmetic
                     shift_reg       <= operand_b;
                     count_reg       <= shamt;
                     shift_right_reg <= alu_control[1];
                     shift_arith_reg <= alu_control[1] & alu_control[0];
                     state_reg       <= SHIFT;
                  end else begin
                     result_reg    <= calc_result;
                     zero_reg      <= (calc_result == '0);
                     overflow_reg  <= calc_overflow;
                     op_err_reg    <= calc_err;
                     out_valid_reg <= 1'b1;
                     state_reg     <= DONE;
                  end
               end
            end
            SHIFT: begin
               shift_reg <= shift_step;
               count_reg <= count_reg - 5'd1;
               if (count_reg == 5'd1) begin
                  result_reg    <= shift_step;
                  zero_reg      <= (shift_step == '0);
                  overflow_reg  <= 1'b0;
                  op_err_reg    <= 1'b0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign zero      = zero_reg;
   assign overflow  = overflow_reg;
   assign op_err    = op_err_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_control;
   logic        shamt_sel;
   logic [4:0]  shamt_in;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        op_err;

   int checks_total  = 0;
   int checks_passed = 0;

   alu_exec_unit #(.WIDTH(32), .ITERATIVE_SHIFT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .shamt_sel(shamt_sel), .shamt_in(shamt_in),
      .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .overflow(overflow), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference model: exact 64-bit arithmetic, then reduce modulo 2^32
   function automatic void model(input logic [3:0] code, input logic sel, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ov, output logic err,
                                 output int lat);
      longint sa, sb, ua, ub, sr, d;
      int amt;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      amt = sel ? int'(sh) : int'(a[4:0]);
      d = longint'(1) << amt;
      r = 32'd0; ov = 1'b0; err = 1'b0; lat = 1;
      case (code)
         4'd0: begin sr = sa + sb; r = sr[31:0]; ov = (sr != longint'($signed(r))); end
         4'd1, 4'd2: begin sr = sa - sb; r = sr[31:0]; ov = (sr != longint'($signed(r))); end
         4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd4: r = (ua < ub) ? 32'd1 : 32'd0;
         4'd5: r = a & b;
         4'd6: r = a | b;
         4'd7: r = a ^ b;
         4'd8: begin sr = (ub % 65536) * 65536; r = sr[31:0]; end
         4'd9: begin sr = (ub * d) % 64'sd4294967296; r = sr[31:0]; end
         4'd10: begin sr = ub / d; r = sr[31:0]; end
         4'd11: begin
            sr = sb / d;
            if (sb < 0 && (sb % d) != 0) sr = sr - 1;
            r = sr[31:0];
         end
         4'd15: r = ~(a | b);
         default: err = 1'b1;
      endcase
      if ((code == 4'd9 || code == 4'd10 || code == 4'd11) && amt != 0) lat = amt + 1;
   endfunction

   task automatic scramble_inputs();
      alu_control = 4'($urandom);
      shamt_sel   = 1'($urandom);
      shamt_in    = 5'($urandom);
      operand_a   = $urandom;
      operand_b   = $urandom;
   endtask

   // Issue one request, measure latency, check result/flags, apply backpressure, release
   task automatic run_op(input string tag, input logic [3:0] code, input logic sel,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] er;
      logic eo, ee;
      int el, lat;
      model(code, sel, sh, a, b, er, eo, ee, el);
      @(negedge clk);
      in_valid = 1'b1; alu_control = code; shamt_sel = sel; shamt_in = sh;
      operand_a = a; operand_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_inputs();
      lat = 1;
      while (!out_valid && lat < 64) begin
         check_value({tag, ".busy_rdy"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check_value({tag, ".lat"}, 32'(lat), 32'(el));
      check_value({tag, ".res"}, result, er);
      check_value({tag, ".zero"}, 32'(zero), 32'(er == 32'd0));
      check_value({tag, ".ovf"}, 32'(overflow), 32'(eo));
      check_value({tag, ".err"}, 32'(op_err), 32'(ee));
      check_value({tag, ".done_rdy"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         scramble_inputs();
         @(posedge clk); #1;
         check_value({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
         check_value({tag, ".hold_res"}, result, er);
         check_value({tag, ".hold_flags"}, {29'd0, zero, overflow, op_err},
                     {29'd0, (er == 32'd0), eo, ee});
         check_value({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_value({tag, ".rel_vld"}, 32'(out_valid), 32'd0);
      check_value({tag, ".rel_rdy"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check_value({tag, ".noqueue"}, 32'(out_valid), 32'd0);
      $display("op %s code=%b a=%08h b=%08h -> res=%08h z=%0d v=%0d e=%0d lat=%0d",
               tag, code, a, b, result, zero, overflow, op_err, lat);
   endtask

   task automatic check_reset_state(input string tag);
      check_value({tag, ".vld"}, 32'(out_valid), 32'd0);
      check_value({tag, ".rdy"}, 32'(in_ready), 32'd1);
      check_value({tag, ".res"}, result, 32'd0);
      check_value({tag, ".flags"}, {29'd0, zero, overflow, op_err}, 32'b100);
   endtask

   logic [31:0] corner [4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_control = 4'd0; shamt_sel = 1'b0; shamt_in = 5'd0;
      operand_a = 32'd0; operand_b = 32'd0;
      #12;
      check_reset_state("rst");
      @(posedge clk); #2;
      rst_n = 1'b1;

      run_op("add_ovf", 4'b0000, 1'b0, 5'd0, 32'h7FFFFFFF, 32'h1, 0);
      run_op("beq",     4'b0001, 1'b0, 5'd0, 32'h1234, 32'h1234, 0);
      run_op("sltu",    4'b0100, 1'b0, 5'd0, 32'h1, 32'hFFFFFFFF, 0);
      run_op("slt",     4'b0011, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h1, 0);
      run_op("sra4",    4'b1011, 1'b1, 5'd4, 32'h0, 32'hF0000000, 0);
      run_op("sll_var", 4'b1001, 1'b0, 5'd0, 32'h00000023, 32'h1, 10);
      run_op("bad1101", 4'b1101, 1'b0, 5'd0, 32'h5, 32'h7, 0);
      run_op("lui",     4'b1000, 1'b0, 5'd0, 32'h0, 32'h0000ABCD, 0);
      run_op("srl0",    4'b1010, 1'b1, 5'd0, 32'h0, 32'h8000_0001, 0);
      run_op("sra31",   4'b1011, 1'b1, 5'd31, 32'h0, 32'h8000_0000, 2);
      run_op("sub_ovf", 4'b0010, 1'b0, 5'd0, 32'h80000000, 32'h1, 0);

      // Reset in the middle of a long shift
      @(negedge clk);
      in_valid = 1'b1; alu_control = 4'b1011; shamt_sel = 1'b1; shamt_in = 5'd20;
      operand_a = 32'h0; operand_b = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("rst_mid");
      @(posedge clk); #2;
      rst_n = 1'b1;
      run_op("post_rst", 4'b0000, 1'b0, 5'd0, 32'd2, 32'd3, 0);

      for (int n = 0; n < 80; n++) begin
         logic [3:0]  code;
         logic [31:0] a, b;
         code = 4'($urandom);
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         run_op($sformatf("rnd%0d", n), code, 1'($urandom), 5'($urandom), a, b,
                $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Registered execute stage of the datapath. Sits directly downstream of the ALU control decoder and consumes its 4-bit operation code and shamt-select bit.
- Performs the selected operation on two operands under a valid/ready handshake.
- Non-shift operations take one cycle. Shifts run iteratively, one bit per cycle, to keep the critical path short.
- Produces result, zero flag (for BEQ/BNE), overflow flag and an invalid-opcode error flag.

Parameters:
- WIDTH, 32, operand/result width in bits (shift amount is always 5 bits).
- ITERATIVE_SHIFT, 1, 1 = shift one bit per cycle; 0 = shifts complete in one cycle like other ops.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request this cycle.
- alu_control  input  4  operation code from the ALU control decoder.
- shamt_sel  input  1  1 = shift amount from shamt_in; 0 = from operand_a[4:0] (variable shifts).
- shamt_in  input  5  instruction shamt field.
- operand_a  input  WIDTH  rs value.
- operand_b  input  WIDTH  rt value or extended immediate; the shifted operand for all shifts.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow on ADD/SUB codes.
- op_err  output  1  unsupported alu_control code.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0.
  - result=0, zero=1, overflow=0, op_err=0, shift counter=0.
- Accept: in_valid && in_ready on a rising edge. Operands, code and shift amount are captured; later input changes are ignored.
- States:
  - IDLE: in_ready=1. On accept of a non-shift op, or a shift with amount 0, or ITERATIVE_SHIFT=0: compute, register result, go to DONE. On accept of a shift with amount>0: load B into the shift register and the amount into the counter, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle shifts 1 bit and decrements the counter. When the counter reaches 0, go to DONE with result registered.
  - DONE: out_valid=1, in_ready=0. Outputs hold stable until out_ready=1, then go to IDLE. There is no same-cycle re-accept, so throughput is at most one op per 2 cycles.
- Latency from accept edge to out_valid:
  - non-shift: 1 cycle.
  - shift of amount n (n>0, iterative): n+1 cycles.
  - shift with ITERATIVE_SHIFT=0: 1 cycle.
- Codes:
  - 0000 ADD: A+B.
  - 0001 SUB: A-B.
  - 0010 SUB (BNE): A-B.
  - 0011 SLT: signed A<B → 1 else 0.
  - 0100 SLTU: unsigned compare.
  - 0101 AND.
  - 0110 OR.
  - 0111 XOR.
  - 1000 LUI: B[15:0]<<16, low half 0.
  - 1001 SLL: B<<amt, zero fill.
  - 1010 SRL: B>>amt, zero fill.
  - 1011 SRA: B>>amt, sign fill from B[WIDTH-1].
  - 1111 NOR: ~(A|B).
  - 1100–1110 and any X/Z: result=0, op_err=1, latency 1.
- Arithmetic and flags:
  - All arithmetic is modulo 2^WIDTH.
  - overflow is set only for codes 0000/0001/0010 (two's-complement rule) and is 0 otherwise.
  - zero is computed on the final registered result.
  - Flags update together with result.
- Shift amount: shamt_sel ? shamt_in : operand_a[4:0], captured at accept. Amounts 0–31 are valid. Amount 0 returns B unchanged in 1 cycle.
- Backpressure: result, zero, overflow and op_err must not change while out_valid=1 and out_ready=0.
- out_ready asserted while out_valid=0 has no effect. in_valid while in_ready=0 is ignored; the request is not queued.
- Reset mid-operation (SHIFT or DONE): abort immediately to the reset values. The pending result is discarded.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT with amount 20 → out_valid=0 and in_ready=1 asynchronously. After release the unit accepts a new op on the first edge.
- ADD overflow: code 0000, A=0x7FFFFFFF, B=1, out_ready=1 → 1 cycle later out_valid=1, result=0x80000000, overflow=1, zero=0.
- BEQ path: code 0001, A=B=0x1234 → result=0, zero=1, overflow=0. Then SLTU with A=1, B=0xFFFFFFFF → result=1.
- Iterative SRA: code 1011, shamt_sel=1, shamt_in=4, B=0xF0000000 → out_valid exactly 5 cycles after accept, result=0xFF000000. in_ready=0 throughout.
- Variable shift and backpressure: code 1001, shamt_sel=0, A=0x00000023 (amt 3), B=0x1 → result=0x8. Hold out_ready=0 for 10 cycles → result stable, in_ready=0, in_valid pulses ignored. Release → IDLE next cycle.
- Invalid code 1101 → op_err=1, result=0, zero=1, latency 1. LUI B=0x0000ABCD → result=0xABCD0000.
